// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: multi-cycle control sequencer for the processor datapath.
// Owns the PC, fetches 9-bit instructions, issues them to the ALU over a
// go/done handshake, resolves branches and strobes register writeback.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   start_i, start_addr_i  start execution at start_addr_i (IDLE only)
//   instr_i, inst_addr_o   instruction memory read data / address (PC)
//   alu_op_o, alu_go_o     ALU opcode (IR[8:5]) and one-cycle start pulse
//   alu_done_i, alu_flag_i ALU completion and branch condition
//   reg_wr_en_o            register-file write strobe (WB, non-branch)
//   done_o, err_o          sticky halt status (normal / error)
//   instr_count_o          retired-instruction counter
module ctrl_sequencer #(
  parameter int unsigned PW      = 10,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic [PW-1:0] start_addr_i,
  input  logic [8:0]    instr_i,
  output logic [PW-1:0] inst_addr_o,
  output logic [3:0]    alu_op_o,
  output logic          alu_go_o,
  input  logic          alu_done_i,
  input  logic          alu_flag_i,
  output logic          reg_wr_en_o,
  output logic          done_o,
  output logic          err_o,
  output logic [15:0]   instr_count_o
);

  localparam int unsigned WW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT
  } state_e;

  state_e        state_q;
  logic [PW-1:0] pc_q;
  logic [8:0]    ir_q;
  logic [WW-1:0] wait_q;
  logic          flag_q;
  logic          alu_go_q;
  logic          reg_wr_en_q;
  logic          done_q;
  logic          err_q;
  logic [15:0]   instr_count_q;

  logic [3:0]    opcode;
  logic          is_branch;
  logic [PW-1:0] pc_d;

  // Decode helpers and next-PC selection for WB.
  assign opcode    = ir_q[8:5];
  assign is_branch = (opcode == 4'd8) || (opcode == 4'd9) || (opcode == 4'd11);
  assign pc_d      = (is_branch && flag_q)
                   ? pc_q + {{(PW-5){ir_q[4]}}, ir_q[4:0]}
                   : pc_q + PW'(1);

  // Sequencer FSM; pulse outputs default low every cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      pc_q          <= '0;
      ir_q          <= '0;
      wait_q        <= '0;
      flag_q        <= 1'b0;
      alu_go_q      <= 1'b0;
      reg_wr_en_q   <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      instr_count_q <= '0;
    end else begin
      alu_go_q    <= 1'b0;
      reg_wr_en_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            pc_q          <= start_addr_i;
            instr_count_q <= '0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            state_q       <= S_FETCH;
          end
        end
        S_FETCH: begin
          ir_q    <= instr_i;
          state_q <= S_DECODE;
        end
        S_DECODE: begin
          if (opcode <= 4'd11) begin
            alu_go_q <= 1'b1;
            wait_q   <= WW'(1);
            state_q  <= S_EXEC;
          end else if (opcode == 4'd15) begin
            done_q  <= 1'b1;
            state_q <= S_HALT;
          end else begin
            err_q   <= 1'b1;
            state_q <= S_HALT;
          end
        end
        S_EXEC: begin
          // Done on the TIMEOUT-th cycle still wins over the timeout.
          if (alu_done_i) begin
            flag_q      <= alu_flag_i;
            reg_wr_en_q <= !is_branch;
            state_q     <= S_WB;
          end else if (wait_q == WW'(TIMEOUT)) begin
            err_q   <= 1'b1;
            state_q <= S_HALT;
          end else begin
            wait_q <= wait_q + WW'(1);
          end
        end
        S_WB: begin
          pc_q          <= pc_d;
          instr_count_q <= instr_count_q + 16'd1;
          state_q       <= S_FETCH;
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign inst_addr_o   = pc_q;
  assign alu_op_o      = ir_q[8:5];
  assign alu_go_o      = alu_go_q;
  assign reg_wr_en_o   = reg_wr_en_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign instr_count_o = instr_count_q;

endmodule

// File: doc/ctrl_sequencer.md
# ctrl_sequencer

Multi-cycle control sequencer for the processor datapath. It holds the program counter, fetches 9-bit instructions, decodes the 4-bit opcode (ADD=0, SUB=1, LSH=2, RSH=3, MOV=4, XOR=5, AND=6, OR=7, BGE=8, BNE=9, RXOR=10, BEQ=11), issues each operation to the ALU over a go/done handshake, and resolves branches and register writeback. It sits between instruction memory, the ALU and the register file, and is the only block that advances the PC.

## Interface
- PW, 10, PC / instruction-address width
- TIMEOUT, 15, maximum cycles spent in EXEC waiting for ALU_done before error
- Clk  in  1  clock; all state changes on rising edge
- Reset  in  1  asynchronous, active-low reset
- Start  in  1  in IDLE, load PC from StartAddr and begin execution
- StartAddr  in  PW  initial PC
- Instr  in  9  instruction memory read data for InstAddr, valid same cycle
- InstAddr  out  PW  current PC
- ALU_op  out  4  opcode driven to ALU, from IR[8:5]
- ALU_go  out  1  one-cycle pulse starting an ALU operation
- ALU_done  in  1  ALU result/flag valid
- ALU_flag  in  1  branch condition true; sampled with ALU_done
- RegWrEn  out  1  register-file write strobe, one cycle
- Done  out  1  level, high in HALT after a normal halt
- Err  out  1  level, high in HALT after illegal opcode or timeout
- InstrCount  out  16  retired-instruction counter

## Operation
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT.
- IDLE: wait for Start. Start=1 -> PC<=StartAddr, InstrCount<=0, Done<=0, Err<=0, go FETCH.
- FETCH: IR<=Instr (InstAddr=PC); go DECODE.
- DECODE: opcode=IR[8:5].
  - 0-11 -> EXEC, ALU_go=1 on the first EXEC cycle only.
  - 15 -> HALT with Done=1 (PC unchanged, not counted as retired).
  - 12-14 -> HALT with Err=1.
- EXEC: hold ALU_op; count wait cycles from 1. ALU_done=1 -> latch ALU_flag, go WB. Counter reaching TIMEOUT without ALU_done -> HALT, Err=1.
- WB, non-branch (0-7, 10): RegWrEn=1, PC<=PC+1.
- WB, branch (8, 9, 11): RegWrEn=0. Latched flag=1 -> PC<=PC+sext(IR[4:0]); else PC<=PC+1.
- WB always: InstrCount<=InstrCount+1 (wraps at 16 bits); go FETCH.
- PC arithmetic modulo 2^PW: wraps from max to 0 and backwards below 0.
- Offset 0 with taken branch re-executes the same instruction; legal.
- HALT: stays until reset; Start ignored. Done and Err are mutually exclusive.
- ALU_op=IR[8:5] in all states. ALU_done outside EXEC is ignored.

## Timing
- Reset asserted (any time, including mid-EXEC) -> immediately: state IDLE, PC=0, IR=0, InstrCount=0, ALU_go=0, RegWrEn=0, Done=0, Err=0, wait counter=0.
- After Reset deasserts, the first Start sample is on the next rising edge.
- Minimum 4 cycles per instruction: FETCH, DECODE, EXEC (ALU_done in the first EXEC cycle), WB.
- ALU_go is asserted exactly one cycle per instruction, in the cycle after DECODE.
- ALU_done in the same cycle as ALU_go is accepted.
- ALU_done on the TIMEOUT-th EXEC cycle is accepted; timeout fires only if ALU_done is still low on that cycle.
- The new PC is visible on InstAddr in the FETCH cycle following WB.
- RegWrEn and the InstrCount increment occur in the WB cycle.
- Done and Err assert on entry to HALT and remain high.

## Test plan
- Reset, StartAddr=0x010, Start pulse; memory holds ADD (9'h000) at 0x010 and HALT (9'h1E0) at 0x011, ALU_done tied to 1 -> ALU_go at cycle 3, RegWrEn at cycle 4, InstAddr=0x011 at cycle 5, Done=1, InstrCount=1.
- BEQ with offset 5'b11110 at PC 0x005, ALU_flag=1 -> next InstAddr=0x003. Same instruction with ALU_flag=0 -> 0x006. RegWrEn stays 0 in both cases.
- Instruction at PC 0x3FF (non-branch) -> next InstAddr=0x000. BNE at 0x001 with offset -2, taken -> next InstAddr=0x3FF.
- Opcode 13 fetched -> HALT, Err=1, Done=0, no ALU_go. ALU_done held low for 15 EXEC cycles -> Err=1. ALU_done first arriving on EXEC cycle 15 -> normal WB.
- Reset pulsed low during EXEC after 3 instructions -> all outputs return to reset values at once, InstrCount=0. A new Start restarts cleanly from StartAddr.
